// File: rtl/lock_code_sender_if.sv
// Bus between the lock code sender and its environment.
// The environment (bench or host logic plus the physical lock) is the master:
// it drives start/code and returns the lock's UNLOCK_Output. The sender is the
// slave: it drives the three lock buttons and the busy/done/unlocked status.
//   start          request a code sequence
//   code           code to send, MSB first
//   RESET_Button   lock clear pulse
//   ZERO_Button    press for a 0 bit
//   ONE_Button     press for a 1 bit
//   UNLOCK_Output  lock's unlock indication (asynchronous to the sender clock)
//   busy           sequence in progress
//   done           one-cycle result-valid pulse
//   unlocked       result of the last completed sequence
interface lock_code_sender_if #(
  parameter int CODE_LEN = 4
);
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                RESET_Button;
  logic                ZERO_Button;
  logic                ONE_Button;
  logic                UNLOCK_Output;
  logic                busy;
  logic                done;
  logic                unlocked;

  modport master (
    output start, code, UNLOCK_Output,
    input  RESET_Button, ZERO_Button, ONE_Button, busy, done, unlocked
  );

  modport slave (
    input  start, code, UNLOCK_Output,
    output RESET_Button, ZERO_Button, ONE_Button, busy, done, unlocked
  );
endinterface

// File: rtl/lock_code_sender.sv
// Drives a button-sequence combination lock in place of manual presses.
// On an accepted start it latches the code, pulses RESET_Button, presses
// ONE_Button/ZERO_Button once per bit (MSB first) with fixed press and gap
// widths, waits for the lock to settle, samples the synchronized unlock
// indication and reports it with a one-cycle done pulse.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-high reset
//   bus      lock_code_sender_if slave side (start/code in, buttons and
//            busy/done/unlocked out, UNLOCK_Output in)
// All outputs are registered from the current state, so they lag the state
// register by one edge; the state machine enters CLR on the accept edge and
// RESET_Button becomes visible on the following edge.
module lock_code_sender #(
  parameter int CODE_LEN      = 4,
  parameter int PULSE_CYCLES  = 4,
  parameter int GAP_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  lock_code_sender_if.slave  bus
);

  localparam int MAX_PG  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_PG > SETTLE_CYCLES) ? MAX_PG : SETTLE_CYCLES;
  localparam int PW      = $clog2(MAX_CYC + 1);
  localparam int BW      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST    = GAP_CYCLES > 0 ? PW'(GAP_CYCLES - 1) : '0;
  localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_TOP     = BW'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_CGAP  = 3'd2,
    S_PRESS = 3'd3,
    S_GAP   = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e              state_q,  state_d;
  logic [PW-1:0]       phase_q,  phase_d;
  logic [BW-1:0]       bit_q,    bit_d;
  logic [CODE_LEN-1:0] code_q,   code_d;
  logic                result_q, result_d;
  logic                sync1_q,  sync2_q;

  logic rst_btn_q,  rst_btn_d;
  logic zero_btn_q, zero_btn_d;
  logic one_btn_q,  one_btn_d;
  logic busy_q,     busy_d;
  logic done_q,     done_d;
  logic unlocked_q, unlocked_d;

  // Two-flop synchronizer for the asynchronous unlock indication.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.UNLOCK_Output;
      sync2_q <= sync1_q;
    end
  end

  // State, counters, latched code and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      code_q     <= '0;
      result_q   <= 1'b0;
      rst_btn_q  <= 1'b0;
      zero_btn_q <= 1'b0;
      one_btn_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      unlocked_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      result_q   <= result_d;
      rst_btn_q  <= rst_btn_d;
      zero_btn_q <= zero_btn_d;
      one_btn_q  <= one_btn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      unlocked_q <= unlocked_d;
    end
  end

  // Next-state logic; phase_q counts cycles spent in the current timed state.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (bus.start) begin
          code_d  = bus.code;
          bit_d   = BIT_TOP;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = S_CGAP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_CGAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = S_PRESS;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_PRESS: begin
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          state_d = S_GAP;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          if (bit_q == '0) begin
            state_d = S_CHECK;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = S_PRESS;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_CHECK: begin
        if (phase_q == SETTLE_LAST) begin
          phase_d  = '0;
          result_d = sync2_q;
          state_d  = S_DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        phase_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state; registered one edge later.
  // Only one state drives any button, so the buttons are mutually exclusive,
  // and every press state is bracketed by all-low gap/idle/check states.
  always_comb begin
    rst_btn_d  = (state_q == S_CLR);
    zero_btn_d = (state_q == S_PRESS) && !code_q[bit_q];
    one_btn_d  = (state_q == S_PRESS) &&  code_q[bit_q];
    busy_d     = (state_q != S_IDLE);
    done_d     = (state_q == S_DONE);
    if (state_q == S_DONE) begin
      unlocked_d = result_q;
    end else begin
      unlocked_d = unlocked_q;
    end
  end

  assign bus.RESET_Button = rst_btn_q;
  assign bus.ZERO_Button  = zero_btn_q;
  assign bus.ONE_Button   = one_btn_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.unlocked     = unlocked_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: a default-parameter instance driving a
// lock model that accepts 1010, and a minimal instance (CODE_LEN=1, P=1, G=1,
// S=3) driving a lock model that accepts a single 1.
module tb_lock_code_sender;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   onehot_bad = 0;

  always #5 clk = ~clk;

  lock_code_sender_if #(.CODE_LEN(4)) ifa ();
  lock_code_sender_if #(.CODE_LEN(1)) ifb ();

  lock_code_sender #(.CODE_LEN(4), .PULSE_CYCLES(4), .GAP_CYCLES(4), .SETTLE_CYCLES(4)) dut_a (
    .clk_i(clk), .reset_i(reset), .bus(ifa.slave)
  );

  lock_code_sender #(.CODE_LEN(1), .PULSE_CYCLES(1), .GAP_CYCLES(1), .SETTLE_CYCLES(3)) dut_b (
    .clk_i(clk), .reset_i(reset), .bus(ifb.slave)
  );

  // Lock model A: clears on RESET_Button, shifts in one bit per press; opens
  // after exactly four presses matching 1010.
  logic [2:0] pa_prev = 3'b000;
  logic [3:0] la_sh   = 4'b0000;
  int         la_cnt  = 0;
  always @(posedge clk) begin
    if (ifa.RESET_Button && !pa_prev[2]) begin
      la_sh  <= 4'b0000;
      la_cnt <= 0;
    end else if (ifa.ONE_Button && !pa_prev[0]) begin
      la_sh  <= {la_sh[2:0], 1'b1};
      la_cnt <= (la_cnt < 7) ? la_cnt + 1 : la_cnt;
    end else if (ifa.ZERO_Button && !pa_prev[1]) begin
      la_sh  <= {la_sh[2:0], 1'b0};
      la_cnt <= (la_cnt < 7) ? la_cnt + 1 : la_cnt;
    end
    pa_prev <= {ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
  end
  assign ifa.UNLOCK_Output = (la_cnt == 4) && (la_sh == 4'b1010);

  // Lock model B: opens after exactly one press of ONE_Button.
  logic [2:0] pb_prev = 3'b000;
  logic       lb_bit  = 1'b0;
  int         lb_cnt  = 0;
  always @(posedge clk) begin
    if (ifb.RESET_Button && !pb_prev[2]) begin
      lb_bit <= 1'b0;
      lb_cnt <= 0;
    end else if (ifb.ONE_Button && !pb_prev[0]) begin
      lb_bit <= 1'b1;
      lb_cnt <= (lb_cnt < 7) ? lb_cnt + 1 : lb_cnt;
    end else if (ifb.ZERO_Button && !pb_prev[1]) begin
      lb_bit <= 1'b0;
      lb_cnt <= (lb_cnt < 7) ? lb_cnt + 1 : lb_cnt;
    end
    pb_prev <= {ifb.RESET_Button, ifb.ZERO_Button, ifb.ONE_Button};
  end
  assign ifb.UNLOCK_Output = (lb_cnt == 1) && lb_bit;

  // Button exclusivity monitor on every cycle of every test.
  always @(negedge clk) begin
    if ((int'(ifa.RESET_Button) + int'(ifa.ZERO_Button) + int'(ifa.ONE_Button)) > 1 ||
        (int'(ifb.RESET_Button) + int'(ifb.ZERO_Button) + int'(ifb.ONE_Button)) > 1) begin
      onehot_bad <= onehot_bad + 1;
      $display("FAIL onehot t=%0t a=%b%b%b b=%b%b%b", $time,
               ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button,
               ifb.RESET_Button, ifb.ZERO_Button, ifb.ONE_Button);
    end
  end

  // Expected {busy, done, RESET, ZERO, ONE} at En, from the timing formulas.
  function automatic logic [4:0] exp_out(input int n, input logic [15:0] c,
                                         input int l, input int p, input int g, input int s);
    int e_done;
    int st;
    logic [4:0] v;
    e_done = (l + 1) * (p + g) + s + 1;
    v = 5'b00000;
    v[4] = (n >= 1) && (n <= e_done);
    v[3] = (n == e_done);
    v[2] = (n >= 1) && (n <= p);
    for (int k = 0; k < l; k++) begin
      st = 1 + (k + 1) * (p + g);
      if (n >= st && n < st + p) begin
        if (c[l-1-k]) v[0] = 1'b1;
        else          v[1] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [3:0] pat(input int m);
    logic [3:0] mv;
    mv = 4'(m);
    return mv ^ 4'hA;
  endfunction

  task automatic test_reset();
    logic [5:0] obs;
    reset = 1'b1;
    ifa.start = 1'b0; ifa.code = 4'h0;
    ifb.start = 1'b0; ifb.code = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== 6'b000000) begin
        bad++; $display("FAIL reset_a i=%0d got=%b exp=000000", i, obs);
      end
      obs = {ifb.unlocked, ifb.busy, ifb.done, ifb.RESET_Button, ifb.ZERO_Button, ifb.ONE_Button};
      total++;
      if (obs !== 6'b000000) begin
        bad++; $display("FAIL reset_b i=%0d got=%b exp=000000", i, obs);
      end
      reset = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_code_1010();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifa.code = 4'b1010; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int n = 0; n <= 48; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp = {(n >= 45), exp_out(n, 16'h000A, 4, 4, 4, 4)};
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL code_1010 n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifa.code = 4'b1010; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n == 20) reset = 1'b0;
      if (n < 20) exp = {1'b1, exp_out(n, 16'h000A, 4, 4, 4, 4)};
      else        exp = 6'b000000;
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL reset_mid n=%0d got=%b exp=%b", n, obs, exp);
      end
      if (n == 19) reset = 1'b1;
    end
    // A fresh sequence after the abort must be complete and correctly timed.
    @(negedge clk);
    ifa.code = 4'b1010; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int n = 0; n <= 47; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp = {(n >= 45), exp_out(n, 16'h000A, 4, 4, 4, 4)};
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL after_reset n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_code_1011();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifa.code = 4'b1011; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp = {(n < 45), exp_out(n, 16'h000B, 4, 4, 4, 4)};
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL code_1011 n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifa.code = 4'b1010; ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int n = 0; n <= 55; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp = {(n >= 45), exp_out(n, 16'h000A, 4, 4, 4, 4)};
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL start_ignored n=%0d got=%b exp=%b", n, obs, exp);
      end
      if (n == 9)  begin ifa.start = 1'b1; ifa.code = 4'b0000; end
      if (n == 10) ifa.start = 1'b0;
      if (n == 44) ifa.start = 1'b1;
      if (n == 45) ifa.start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifa.code = pat(0); ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.code = pat(1);
    for (int n = 0; n <= 95; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (n <= 46) exp[4:0] = exp_out(n, {12'h000, pat(0)}, 4, 4, 4, 4);
      else         exp[4:0] = exp_out(n - 46, {12'h000, pat(46)}, 4, 4, 4, 4);
      exp[5] = (n < 91);
      obs = {ifa.unlocked, ifa.busy, ifa.done, ifa.RESET_Button, ifa.ZERO_Button, ifa.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL back_to_back n=%0d got=%b exp=%b", n, obs, exp);
      end
      ifa.code = pat(n + 1);
      if (n == 91) ifa.start = 1'b0;
    end
  endtask

  task automatic test_short();
    logic [5:0] obs, exp;
    @(negedge clk);
    ifb.code = 1'b1; ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      exp = {(n >= 8), exp_out(n, 16'h0001, 1, 1, 1, 3)};
      obs = {ifb.unlocked, ifb.busy, ifb.done, ifb.RESET_Button, ifb.ZERO_Button, ifb.ONE_Button};
      total++;
      if (obs !== exp) begin
        bad++; $display("FAIL short n=%0d got=%b exp=%b", n, obs, exp);
      end
    end
  endtask

  task automatic test_onehot();
    total++;
    if (onehot_bad !== 0) begin
      bad++; $display("FAIL onehot_total got=%0d exp=0", onehot_bad);
    end
  endtask

  initial begin
    test_reset();
    test_code_1010();
    test_reset_mid();
    test_code_1011();
    test_start_ignored();
    test_back_to_back();
    test_short();
    repeat (2) @(posedge clk);
    #1;
    test_onehot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_code_sender.md
# lock_code_sender

Sequencer that drives a button-sequence combination lock from the keypad side, replacing manual button presses. On `start` it latches a binary code, clears the lock with a `RESET_Button` pulse, and presses `ONE_Button`/`ZERO_Button` once per code bit, MSB first, with fixed press and release widths. It then samples the lock's `UNLOCK_Output` and reports pass/fail. It is used for automated lock bring-up and for self-test of the lock datapath.

## Interface
- `CODE_LEN`, default 4: code length in bits. Legal range 1..16.
- `PULSE_CYCLES`, default 4: clock cycles each button is held high. Must be ≥1.
- `GAP_CYCLES`, default 4: all-buttons-low cycles after every press. Must be ≥1.
- `SETTLE_CYCLES`, default 4: cycles between the last gap and sampling the unlock input. Must be ≥3.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a sequence; sampled only in IDLE.
- `code`  in  CODE_LEN  code to send; latched on the accepted `start` edge; bit CODE_LEN-1 is sent first.
- `RESET_Button`  out  1  lock clear pulse.
- `ZERO_Button`  out  1  press for a 0 bit.
- `ONE_Button`  out  1  press for a 1 bit.
- `UNLOCK_Output`  in  1  lock's unlock indication; asynchronous to `clk`.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `unlocked`  out  1  result of the last completed sequence; held until the next `done`.

## Operation
- All outputs are registered. Reset value of every output is 0.
- `UNLOCK_Output` passes through a 2-flop synchronizer before any use.
- The state machine has these states:
  - IDLE: if `start`=1, latch `code`, load the bit counter with CODE_LEN-1, go to CLR.
  - CLR: `RESET_Button`=1 for PULSE_CYCLES cycles, then go to CGAP.
  - CGAP: all buttons 0 for GAP_CYCLES cycles, then go to PRESS.
  - PRESS: drive the button selected by the current bit high for PULSE_CYCLES cycles, then go to GAP.
  - GAP: all buttons 0 for GAP_CYCLES cycles. If the bit counter is 0, go to CHECK; otherwise decrement it and go to PRESS.
  - CHECK: wait SETTLE_CYCLES cycles. On the last cycle, capture the synchronized unlock value, then go to DONE.
  - DONE: `done`=1 and `unlocked` is updated, both for one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- At most one of `RESET_Button`, `ZERO_Button`, `ONE_Button` is high in any cycle. Every press is preceded and followed by at least one all-low cycle.
- `start` outside IDLE is ignored, including in DONE. Changes to `code` after latching have no effect.
- `reset` in any state: next edge returns to IDLE, all outputs 0, `unlocked` cleared to 0, no `done` pulse. The aborted sequence is not resumed.
- The phase counter width is ceil(log2(max(PULSE_CYCLES, GAP_CYCLES, SETTLE_CYCLES)+1)). The bit counter width is ceil(log2(CODE_LEN)) with a minimum of 1.

## Timing
- E0 is the edge where `start`=1 is sampled in IDLE. En is the n-th following edge; a signal "at En" changes at En.
- `busy` rises at E1. `RESET_Button` is high from E1 to E(PULSE_CYCLES+1).
- With P = PULSE_CYCLES, G = GAP_CYCLES, S = SETTLE_CYCLES, L = CODE_LEN:
  - Bit k (k=0 is the MSB) press rises at E(1+(k+1)(P+G)) and lasts P cycles.
  - `done` is high at E((L+1)(P+G)+S+1) for one cycle.
  - `busy` falls one edge after `done` rises.
- With defaults: clear pulse E1–E4, presses at E9/E17/E25/E33, CHECK E41–E44, `done` at E45, `busy` falls at E46.
- If `start` is held high continuously, the next sequence's start is sampled at E46 and its `RESET_Button` rises at E47.
- The unlock sample reflects the lock's state at least S-2 cycles after the last press falls.

## Test plan
- Defaults, `code`=4'b1010, bench lock model accepting 1010: `ONE_Button` rises at E9 and E25, `ZERO_Button` at E17 and E33, each 4 cycles wide; `done` at E45; `unlocked`=1.
- Same model, `code`=4'b1011: identical timing except `ONE_Button` at E33; `done` at E45 with `unlocked`=0. `unlocked` holds 0 until the next `done`.
- `start` pulsed at E10 and E45 during a run: no effect on the output trace; the next accepted `start` only when `busy`=0.
- `reset` asserted at E20: at E21 all outputs are 0 and `busy`=0, with no `done`. A following `start` produces a complete, correctly timed sequence.
- Continuous `start`=1 with `code` changing every cycle: back-to-back runs each sending the value latched at its accept edge; `RESET_Button` at E47 for the second run.
- `CODE_LEN`=1, P=1, G=1, S=3, `code`=1: `RESET_Button` at E1, `ONE_Button` at E3, `done` at E8. The one-hot button property is checked by assertion on every cycle of every test.
